// File: rtl/frame_capture_binarizer_if.sv
// Pixel input stream from the camera recovery stage and the frame-buffer write port.
interface frame_capture_binarizer_if #(
    parameter int ADDR_WIDTH = 18,
    parameter int OUT_BITS   = 1
);
    logic [15:0]           pixel_in;
    logic [10:0]           hcount_in;
    logic [9:0]            vcount_in;
    logic                  valid_in;
    logic [ADDR_WIDTH-1:0] wr_addr_out;
    logic [OUT_BITS-1:0]   wr_data_out;
    logic                  wr_en_out;

    modport master (
        output pixel_in, hcount_in, vcount_in, valid_in,
        input  wr_addr_out, wr_data_out, wr_en_out
    );

    modport slave (
        input  pixel_in, hcount_in, vcount_in, valid_in,
        output wr_addr_out, wr_data_out, wr_en_out
    );
endinterface

// File: rtl/frame_capture_binarizer.sv
// RGB565 -> luma -> quantised pixel, cropped into a frame buffer, with a capture FSM that
// only ever stores whole frames (live, freeze at frame end, single-shot).
module frame_capture_binarizer #(
    parameter int SRC_WIDTH  = 640,
    parameter int SRC_HEIGHT = 480,
    parameter int OUT_WIDTH  = 480,
    parameter int OUT_HEIGHT = 480,
    parameter int OUT_BITS   = 1,
    parameter int AVG_LOG2   = 3,
    parameter int ADDR_WIDTH = $clog2(OUT_WIDTH*OUT_HEIGHT)
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    frame_capture_binarizer_if.slave pix_if,
    input  logic [1:0]               mode_in,
    input  logic [7:0]               thresh_in,
    input  logic signed [7:0]        offset_in,
    input  logic [10:0]              crop_x_in,
    input  logic [9:0]               crop_y_in,
    input  logic                     capture_in,
    input  logic                     shot_in,
    output logic [2:0]               state_out,
    output logic [7:0]               frame_count_out
);
    localparam int AVG_N = 1 << AVG_LOG2;
    localparam int SUM_W = 8 + AVG_LOG2;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OUT_WIDTH*OUT_HEIGHT-1);
    localparam logic [10:0]           MAX_CX    = 11'(SRC_WIDTH-OUT_WIDTH);
    localparam logic [9:0]            MAX_CY    = 10'(SRC_HEIGHT-OUT_HEIGHT);
    localparam logic [AVG_LOG2:0]     CNT_FULL  = (AVG_LOG2+1)'(AVG_N);

    typedef enum logic [2:0] {
        S_LIVE = 3'd0, S_FREEZING = 3'd1, S_FROZEN = 3'd2, S_ARMED = 3'd3, S_SHOT = 3'd4
    } state_t;

    function automatic logic [7:0] rgb_to_luma(input logic [15:0] p);
        logic [7:0]  r8, g8, b8;
        logic [15:0] acc;
        r8  = {p[15:11], p[15:13]};
        g8  = {p[10:5], p[10:9]};
        b8  = {p[4:0], p[4:2]};
        acc = 16'(77*r8 + 150*g8 + 29*b8);
        return acc[15:8];
    endfunction

    function automatic logic [7:0] sat_u8(input logic signed [9:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 10'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    state_t                state_q, target_q;
    logic [1:0]            mode_q;
    logic [7:0]            thr_q;
    logic signed [7:0]     off_q;
    logic [10:0]           cx_q, cx_clamp, cx_eff;
    logic [9:0]            cy_q, cy_clamp, cy_eff;
    logic                  fs, in_win, admit, fe;
    logic                  busy_q, blk_q, whole_frame_q;
    logic                  vld_p0, en_p0, whole_p0, first_p0;
    logic [7:0]            luma_p0;
    logic [10:0]           col_p0;
    logic [9:0]            row_p0;
    logic                  en_p1, whole_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [OUT_BITS-1:0]   data_p1, q_data;
    logic [SUM_W-1:0]      sum_q;
    logic [7:0]            hist_q [AVG_N];
    logic [AVG_LOG2:0]     cnt_q;
    logic [7:0]            mean, adapt_thr;
    logic signed [9:0]     adapt_sum;
    logic                  q_bit;

    assign cx_clamp = (crop_x_in > MAX_CX) ? MAX_CX : crop_x_in;
    assign cy_clamp = (crop_y_in > MAX_CY) ? MAX_CY : crop_y_in;
    assign fs       = pix_if.valid_in && pix_if.hcount_in == '0 && pix_if.vcount_in == '0;
    // The frame-start pixel itself must already see the new crop window.
    assign cx_eff   = fs ? cx_clamp : cx_q;
    assign cy_eff   = fs ? cy_clamp : cy_q;
    assign in_win   = ({1'b0, pix_if.hcount_in} >= {1'b0, cx_eff})
                   && ({1'b0, pix_if.hcount_in} <  {1'b0, cx_eff} + 12'(OUT_WIDTH))
                   && ({1'b0, pix_if.vcount_in} >= {1'b0, cy_eff})
                   && ({1'b0, pix_if.vcount_in} <  {1'b0, cy_eff} + 11'(OUT_HEIGHT));
    assign fe       = en_p1 && addr_p1 == LAST_ADDR;

    // A frame already being written must finish; a new frame start seen during
    // FREEZING/SHOT is refused so the buffer never mixes two frames.
    always_comb begin
        admit = 1'b0;
        case (state_q)
            S_LIVE:             admit = 1'b1;
            S_FREEZING, S_SHOT: admit = !blk_q && !(fs && busy_q);
            S_ARMED:            admit = fs;
            S_FROZEN:           admit = fs && (!capture_in || shot_in);
            default:            admit = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= S_ARMED;
            target_q <= S_LIVE;
        end else begin
            case (state_q)
                S_LIVE:     if (capture_in) state_q <= S_FREEZING;
                S_FREEZING: if (fe) state_q <= S_FROZEN;
                S_FROZEN: begin
                    if (!capture_in) begin
                        if (fs) state_q <= S_LIVE;
                        else begin
                            state_q  <= S_ARMED;
                            target_q <= S_LIVE;
                        end
                    end else if (shot_in) begin
                        if (fs) state_q <= S_SHOT;
                        else begin
                            state_q  <= S_ARMED;
                            target_q <= S_SHOT;
                        end
                    end
                end
                S_ARMED:    if (fs) state_q <= target_q;
                S_SHOT:     if (fe) state_q <= capture_in ? S_FROZEN : S_LIVE;
                default:    state_q <= S_ARMED;
            endcase
        end
    end

    assign state_out = state_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mode_q        <= '0;
            thr_q         <= '0;
            off_q         <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            busy_q        <= 1'b0;
            blk_q         <= 1'b0;
            whole_frame_q <= 1'b0;
        end else begin
            if (fs) begin
                mode_q        <= mode_in;
                thr_q         <= thresh_in;
                off_q         <= offset_in;
                cx_q          <= cx_clamp;
                cy_q          <= cy_clamp;
                whole_frame_q <= admit;
            end
            if (fs && admit)
                busy_q <= 1'b1;
            else if (fe)
                busy_q <= 1'b0;
            if (state_q != S_FREEZING && state_q != S_SHOT)
                blk_q <= 1'b0;
            else if (fs && busy_q)
                blk_q <= 1'b1;
        end
    end

    // Stage p0: luma conversion and window-relative coordinates
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_p0   <= 1'b0;
            en_p0    <= 1'b0;
            whole_p0 <= 1'b0;
        end else begin
            vld_p0   <= pix_if.valid_in && in_win;
            en_p0    <= pix_if.valid_in && in_win && admit;
            whole_p0 <= fs ? admit : whole_frame_q;
        end
    end

    always_ff @(posedge clk_in) begin
        luma_p0  <= rgb_to_luma(pix_if.pixel_in);
        col_p0   <= pix_if.hcount_in - cx_eff;
        row_p0   <= pix_if.vcount_in - cy_eff;
        first_p0 <= pix_if.hcount_in == cx_eff;
    end

    always_comb begin
        mean      = sum_q[SUM_W-1:AVG_LOG2];
        adapt_sum = $signed({2'b00, mean}) + $signed({{2{off_q[7]}}, off_q});
        adapt_thr = (cnt_q == CNT_FULL && !first_p0) ? sat_u8(adapt_sum) : thr_q;
        q_bit     = 1'b0;
        case (mode_q)
            2'b00:   q_bit = luma_p0 > thr_q;
            2'b01:   q_bit = luma_p0 > adapt_thr;
            2'b11:   q_bit = !(luma_p0 > thr_q);
            default: q_bit = 1'b0;
        endcase
        q_data = (mode_q == 2'b10) ? luma_p0[7 -: OUT_BITS] : {OUT_BITS{q_bit}};
    end

    // Stage p1: quantise and update the row running mean (after the compare)
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            en_p1    <= 1'b0;
            whole_p1 <= 1'b0;
            sum_q    <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < AVG_N; i++) hist_q[i] <= '0;
        end else begin
            en_p1    <= en_p0;
            whole_p1 <= whole_p0;
            if (vld_p0) begin
                if (first_p0) begin
                    sum_q <= SUM_W'(luma_p0);
                    cnt_q <= (AVG_LOG2+1)'(1);
                end else if (cnt_q == CNT_FULL) begin
                    sum_q <= sum_q + SUM_W'(luma_p0) - SUM_W'(hist_q[AVG_N-1]);
                end else begin
                    sum_q <= sum_q + SUM_W'(luma_p0);
                    cnt_q <= cnt_q + 1'b1;
                end
                hist_q[0] <= luma_p0;
                for (int i = 1; i < AVG_N; i++) hist_q[i] <= hist_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        addr_p1 <= ADDR_WIDTH'(32'(col_p0) + 32'(row_p0) * OUT_WIDTH);
        data_p1 <= q_data;
    end

    // Stage p2: write port and frame accounting
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pix_if.wr_en_out   <= 1'b0;
            pix_if.wr_addr_out <= '0;
            pix_if.wr_data_out <= '0;
            frame_count_out    <= '0;
        end else begin
            pix_if.wr_en_out   <= en_p1;
            pix_if.wr_addr_out <= addr_p1;
            pix_if.wr_data_out <= data_p1;
            if (fe && whole_p1)
                frame_count_out <= frame_count_out + 8'd1;
        end
    end
endmodule
